// File: rtl/ro_sweep_meter.sv
// Sequencer for a bank of keyed ring oscillators. It runs one oscillator at a time,
// counts its edges over a clk window, and raises a sticky alarm on out-of-band counts.
//
// state      | meaning
// ST_IDLE    | bank disabled, waiting for start
// ST_SETTLE  | current ring enabled, let it run before counting
// ST_MEASURE | counting synced rising edges for max(window,1) cycles
// ST_REPORT  | ring disabled, result published, alarm evaluated, choose next point
module ro_sweep_meter #(
  parameter int NUM_RO = 4,
  parameter int KEY_W  = 2,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 8,
  localparam int SEL_W = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [WIN_W-1:0]  window,
  input  logic [CNT_W-1:0]  lo_thr,
  input  logic [CNT_W-1:0]  hi_thr,
  input  logic              alarm_clr,
  input  logic [NUM_RO-1:0] ro_in,
  output logic [NUM_RO-1:0] ro_enable,
  output logic [KEY_W-1:0]  ro_key,
  output logic              busy,
  output logic              done,
  output logic              last,
  output logic [CNT_W-1:0]  count,
  output logic [SEL_W-1:0]  meas_sel,
  output logic [KEY_W-1:0]  meas_key,
  output logic              alarm
);

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_REPORT} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [KEY_W-1:0]   cur_key_q, cur_key_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_RO-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic               prev_q, prev_d;
  logic               done_q, done_d, last_q, last_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SEL_W-1:0]   meas_sel_q, meas_sel_d;
  logic [KEY_W-1:0]   meas_key_q, meas_key_d;
  logic               alarm_q, alarm_d;

  logic               ro_bit, ro_edge, final_pt, run_active;
  logic [CNT_W-1:0]   cnt_inc;
  logic [TMR_W-1:0]   settle_ld, win_ld;

  always_comb begin
    ro_bit = 1'b0;
    for (int i = 0; i < NUM_RO; i++)
      if (cur_sel_q == SEL_W'(i)) ro_bit = sync2_q[i];
  end

  assign ro_edge    = ro_bit & ~prev_q;
  assign cnt_inc    = (ro_edge && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign final_pt   = (cur_sel_q == SEL_W'(NUM_RO - 1)) && (&cur_key_q);
  assign settle_ld  = TMR_W'(SETTLE - 1);
  assign win_ld     = (win_q == '0) ? '0 : TMR_W'(win_q) - TMR_W'(1);
  assign run_active = (state_q == ST_SETTLE) || (state_q == ST_MEASURE);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cur_sel_d  = cur_sel_q;
    cur_key_d  = cur_key_q;
    win_d      = win_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    tmr_d      = tmr_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    meas_sel_d = meas_sel_q;
    meas_key_d = meas_key_q;
    done_d     = 1'b0;
    last_d     = 1'b0;
    alarm_d    = alarm_q & ~alarm_clr;
    sync1_d    = ro_in;
    sync2_d    = sync1_q;
    // previous-value register follows the selected bit in every state, so
    // MEASURE never starts on a stale edge
    prev_d     = ro_bit;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETTLE;
          mode_d    = mode;
          cur_sel_d = mode ? '0 : sel;
          cur_key_d = mode ? '0 : key_in;
          win_d     = window;
          lo_d      = lo_thr;
          hi_d      = hi_thr;
          tmr_d     = settle_ld;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == '0) begin
          state_d = ST_MEASURE;
          tmr_d   = win_ld;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_MEASURE: begin
        cnt_d = cnt_inc;
        if (tmr_q == '0) begin
          state_d    = ST_REPORT;
          done_d     = 1'b1;
          last_d     = ~mode_q | final_pt;
          count_d    = cnt_inc;
          meas_sel_d = cur_sel_q;
          meas_key_d = cur_key_q;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_REPORT: begin
        if ((count_q < lo_q) || (count_q > hi_q)) alarm_d = 1'b1;
        if (!mode_q || final_pt) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_SETTLE;
          tmr_d     = settle_ld;
          cur_key_d = cur_key_q + KEY_W'(1);
          if (&cur_key_q) cur_sel_d = cur_sel_q + SEL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      cur_sel_q  <= '0;
      cur_key_q  <= '0;
      win_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      tmr_q      <= '0;
      cnt_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= 1'b0;
      done_q     <= 1'b0;
      last_q     <= 1'b0;
      count_q    <= '0;
      meas_sel_q <= '0;
      meas_key_q <= '0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cur_sel_q  <= cur_sel_d;
      cur_key_q  <= cur_key_d;
      win_q      <= win_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      tmr_q      <= tmr_d;
      cnt_q      <= cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      done_q     <= done_d;
      last_q     <= last_d;
      count_q    <= count_d;
      meas_sel_q <= meas_sel_d;
      meas_key_q <= meas_key_d;
      alarm_q    <= alarm_d;
    end
  end

  always_comb begin
    ro_enable = '0;
    if (run_active)
      for (int i = 0; i < NUM_RO; i++) ro_enable[i] = (cur_sel_q == SEL_W'(i));
  end

  assign ro_key   = run_active ? cur_key_q : '0;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign last     = last_q;
  assign count    = count_q;
  assign meas_sel = meas_sel_q;
  assign meas_key = meas_key_q;
  assign alarm    = alarm_q;

endmodule
